rf_multiport_sb: RTL and testbench
==================================

// Module: rf_multiport_sb
// PURPOSE
//  Parametrised MIPS register file for the multi-cycle-multiply CPU, with N read ports and two write ports:
//  port 0 is pipeline writeback, port 1 is long-latency (mult/div/load) writeback.
//  Adds write-through bypass, HI/LO pair, per-register busy scoreboard and a sequential soft-clear FSM.
//  Sits between decode (reads, reserves) and writeback/multiply unit (writes).
// PARAMETERS
//  DW       32  data width of every register, HI and LO
//  AW       5   address width; DEPTH = 2**AW registers
//  NRD      2   number of read ports (1..4)
//  ZERO_R0  1   1: r0 hardwired to 0, never written, never busy
//  BYPASS   1   1: same-cycle write data forwarded to read ports
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst        in   1        asynchronous, active-high reset
//  rd_addr    in   NRD*AW   read addresses, port k at [k*AW +: AW]
//  rd_data    out  NRD*DW   read data, port k at [k*DW +: DW]
//  rd_busy    out  NRD      1 = register of port k awaits a long-latency result
//  we0        in   1        write enable, port 0 (pipeline)
//  waddr0     in   AW       write address, port 0
//  wdata0     in   DW       write data, port 0
//  we1        in   1        write enable, port 1 (long-latency); clears busy bit
//  waddr1     in   AW       write address, port 1
//  wdata1     in   DW       write data, port 1
//  res_valid  in   1        reserve request: mark res_addr busy
//  res_addr   in   AW       register to reserve
//  hilo_we    in   1        write HI and LO together
//  hi_wdata   in   DW       HI write data
//  lo_wdata   in   DW       LO write data
//  hi_rdata   out  DW       HI read data
//  lo_rdata   out  DW       LO read data
//  clr_req    in   1        soft-clear request (single-cycle pulse)
//  clr_busy   out  1        1 while soft clear in progress
// BEHAVIOUR
//  Reset: all registers, HI, LO = 0; busy vector = 0; FSM = IDLE; clear counter = 0; clr_busy = 0. Reset mid-clear aborts to IDLE.
//  Reads: combinational; zero-cycle latency for read data, busy and HI/LO.
//  Bypass (BYPASS=1): a read whose address matches an enabled write this cycle returns that wdata.
//    Port 0 match beats port 1.
//    rd_busy is forced 0 when we1 matches the read address.
//    HI/LO likewise return hi_wdata/lo_wdata when hilo_we.
//  Writes: committed on posedge.
//    we0 and we1 to the same address: port 0 data stored.
//    Busy bit is cleared by we1 regardless of which port's data is stored.
//  ZERO_R0=1: writes/reserves to r0 are dropped; reads of r0 return 0 and busy 0, no bypass.
//  Scoreboard: res_valid sets busy[res_addr]; we1 clears busy[waddr1].
//    Both on the same address in the same cycle: busy ends set (reserve wins).
//    we0 does not touch busy.
//  FSM IDLE -> CLEAR on clr_req.
//    CLEAR writes 0 to register cnt and clears busy[cnt] each cycle, cnt 0..DEPTH-1, then returns to IDLE.
//    Lasts exactly DEPTH cycles.
//    clr_busy = 1 in CLEAR; HI/LO also zeroed on the first CLEAR cycle.
//    In CLEAR: we0, we1, hilo_we, res_valid and clr_req are ignored; bypass is disabled.
//    Reads return current stored (partially cleared) contents.
//  clr_req while in CLEAR: ignored (no restart, no extension).
//  Out-of-range NRD: elaboration error via generate guard.
// STRUCTURE
//  Shared include rf_defs.vh: default DW/AW/NRD, FSM state encodings (RF_IDLE=1'b0, RF_CLEAR=1'b1).
//  Sub-module rf_scoreboard: DEPTH-bit busy vector with set/clear/flush, NRD combinational lookups.
//  Top holds storage array, HI/LO, bypass muxes, clear FSM and counter.
// TESTING
//  1 rst pulse mid-run -> every rd_data, hi/lo_rdata = 0, rd_busy = 0, clr_busy = 0 immediately (async).
//  2 we0 r5=0x1234_5678 while reading r5 on port 0 -> same-cycle rd_data0 = 0x1234_5678;
//    next cycle stored; we0 r0=0xFFFF_FFFF -> r0 reads 0.
//  3 we0 and we1 both to r7 (0xAAAA / 0xBBBB) -> r7 = 0xAAAA; a pending busy[7] is cleared.
//  4 res_valid r9 -> rd_busy = 1 next cycle.
//    we1 r9=0x42 -> same-cycle rd_busy = 0, rd_data = 0x42.
//    res_valid and we1 on r9 together -> busy stays 1.
//  5 Fill r1..r31 with index, clr_req -> clr_busy high exactly 32 cycles, we0 during clear dropped;
//    r3 = 0 after cycle 4, r20 still 20 until cycle 21; all zero at end.
//  6 hilo_we HI=0xDEAD, LO=0xBEEF -> bypassed same cycle, held after;
//    rst asserted at clear cycle 10 -> IDLE, clr_busy = 0.

Source files
------------

// File: rtl/rf_multiport_sb_pkg.sv
// Shared definitions for the multi-port MIPS register file.
// Holds the default geometry (data width, address width, read-port count)
// and the soft-clear FSM state type used by the top level.
// No ports: this is a package imported by the rf_multiport_sb files.
package rf_multiport_sb_pkg;

  localparam int RF_DEF_DW  = 32;
  localparam int RF_DEF_AW  = 5;
  localparam int RF_DEF_NRD = 2;

  // Soft-clear sequencer states. IDLE serves normal traffic; CLEAR walks
  // every register once and blocks all writes, reserves and bypassing.
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rfState_e;

endpackage

// File: rtl/rf_multiport_sb_if.sv
// Bus between the CPU front end (decode / writeback / multiply unit) and the
// register file.
//   rd_addr/rd_data/rd_busy   : NRD combinational read ports, port k packed at k*AW / k*DW
//   we0/waddr0/wdata0         : pipeline writeback port
//   we1/waddr1/wdata1         : long-latency writeback port, also releases the busy bit
//   res_valid/res_addr        : reserve a destination register (mark busy)
//   hilo_we/hi_wdata/lo_wdata : paired HI/LO write; hi_rdata/lo_rdata read back
//   clr_req/clr_busy          : soft-clear request pulse and in-progress flag
// master = CPU side driving requests, slave = register file.
interface rf_multiport_sb_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              we0;
  logic [AW-1:0]     waddr0;
  logic [DW-1:0]     wdata0;
  logic              we1;
  logic [AW-1:0]     waddr1;
  logic [DW-1:0]     wdata1;
  logic              res_valid;
  logic [AW-1:0]     res_addr;
  logic              hilo_we;
  logic [DW-1:0]     hi_wdata;
  logic [DW-1:0]     lo_wdata;
  logic [DW-1:0]     hi_rdata;
  logic [DW-1:0]     lo_rdata;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1,
           res_valid, res_addr, hilo_we, hi_wdata, lo_wdata, clr_req,
    input  rd_data, rd_busy, hi_rdata, lo_rdata, clr_busy
  );

  modport slave (
    input  rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1,
           res_valid, res_addr, hilo_we, hi_wdata, lo_wdata, clr_req,
    output rd_data, rd_busy, hi_rdata, lo_rdata, clr_busy
  );

endinterface

// File: rtl/rf_multiport_sb_scoreboard.sv
// Busy scoreboard: one bit per register, set when decode reserves a
// destination for a long-latency result, cleared when that result is
// written back or when the soft clear walks past the register.
//   clk, rst          : clock, async active-high reset
//   setEn_i/setAddr_i : reserve request (already gated by the caller)
//   clrEn_i/clrAddr_i : long-latency writeback release
//   flushEn_i/flushAddr_i : soft-clear of a single entry
//   lookupAddr_i      : NRD packed read addresses
//   busy_o            : raw stored busy bit for each read port
module rf_multiport_sb_scoreboard #(
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              setEn_i,
  input  logic [AW-1:0]     setAddr_i,
  input  logic              clrEn_i,
  input  logic [AW-1:0]     clrAddr_i,
  input  logic              flushEn_i,
  input  logic [AW-1:0]     flushAddr_i,
  input  logic [NRD*AW-1:0] lookupAddr_i,
  output logic [NRD-1:0]    busy_o
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next-state of the busy vector. A reserve is applied after the release
  // so that reserving and releasing the same register leaves it busy:
  // the new reservation belongs to a younger instruction.
  always_comb begin
    busy_d = busy_q;
    if (clrEn_i) begin
      busy_d[clrAddr_i] = 1'b0;
    end
    if (setEn_i) begin
      busy_d[setAddr_i] = 1'b1;
    end
    if (flushEn_i) begin
      busy_d[flushAddr_i] = 1'b0;
    end
  end

  // Busy vector register, wiped by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Combinational lookup for each read port.
  always_comb begin
    busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      busy_o[k] = busy_q[lookupAddr_i[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multi-port MIPS register file for the multi-cycle-multiply CPU.
// Storage array, HI/LO pair, write-through bypass, busy scoreboard and a
// sequential soft-clear that zeroes one register per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   rfBus    : slave side of rf_multiport_sb_if (read ports, two write ports,
//              reserve, HI/LO, soft clear)
module rf_multiport_sb
  import rf_multiport_sb_pkg::*;
#(
  parameter int DW      = RF_DEF_DW,
  parameter int AW      = RF_DEF_AW,
  parameter int NRD     = RF_DEF_NRD,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic clk,
  input  logic rst,
  rf_multiport_sb_if.slave rfBus
);

  localparam int DEPTH = 1 << AW;

  if (NRD < 1 || NRD > 4) begin : g_badNrd
    $error("rf_multiport_sb: NRD must be in 1..4");
  end

  logic [DW-1:0]     regFile_q [DEPTH];
  logic [DW-1:0]     hi_q;
  logic [DW-1:0]     lo_q;
  rfState_e          state_q;
  logic [AW-1:0]     clrCnt_q;
  logic              clrBusy_q;

  logic              inIdle;
  logic              bypOn;
  logic              wr0En;
  logic              wr1En;
  logic              resEn;
  logic              hiloEn;
  logic [NRD-1:0]    sbBusy;
  logic [NRD*DW-1:0] rdData;
  logic [NRD-1:0]    rdBusy;

  function automatic logic isR0(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  // Every request is qualified by IDLE so the clear sequence owns the
  // array exclusively; r0 traffic is dropped here once for all consumers.
  always_comb begin
    inIdle = (state_q == RF_IDLE);
    bypOn  = (BYPASS != 0);
    wr0En  = rfBus.we0 && inIdle && !isR0(rfBus.waddr0);
    wr1En  = rfBus.we1 && inIdle && !isR0(rfBus.waddr1);
    resEn  = rfBus.res_valid && inIdle && !isR0(rfBus.res_addr);
    hiloEn = rfBus.hilo_we && inIdle;
  end

  rf_multiport_sb_scoreboard #(
    .AW  (AW),
    .NRD (NRD)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .setEn_i      (resEn),
    .setAddr_i    (rfBus.res_addr),
    .clrEn_i      (wr1En),
    .clrAddr_i    (rfBus.waddr1),
    .flushEn_i    (state_q == RF_CLEAR),
    .flushAddr_i  (clrCnt_q),
    .lookupAddr_i (rfBus.rd_addr),
    .busy_o       (sbBusy)
  );

  // Register array. During CLEAR only the swept entry changes. Otherwise
  // port 1 is applied first and port 0 second, so a same-address collision
  // keeps the pipeline (port 0) data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (state_q == RF_CLEAR) begin
      regFile_q[clrCnt_q] <= '0;
    end else begin
      if (wr1En) begin
        regFile_q[rfBus.waddr1] <= rfBus.wdata1;
      end
      if (wr0En) begin
        regFile_q[rfBus.waddr0] <= rfBus.wdata0;
      end
    end
  end

  // HI/LO pair, zeroed together on the first cycle of a soft clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == RF_CLEAR && clrCnt_q == '0) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hiloEn) begin
      hi_q <= rfBus.hi_wdata;
      lo_q <= rfBus.lo_wdata;
    end
  end

  // Soft-clear sequencer. The counter sweeps 0..DEPTH-1, one register per
  // cycle, so CLEAR lasts exactly DEPTH cycles. clr_req is only looked at
  // in IDLE, so a request during a sweep neither restarts nor extends it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RF_IDLE;
      clrCnt_q  <= '0;
      clrBusy_q <= 1'b0;
    end else begin
      case (state_q)
        RF_IDLE: begin
          if (rfBus.clr_req) begin
            state_q   <= RF_CLEAR;
            clrCnt_q  <= '0;
            clrBusy_q <= 1'b1;
          end
        end
        RF_CLEAR: begin
          if (clrCnt_q == {AW{1'b1}}) begin
            state_q   <= RF_IDLE;
            clrCnt_q  <= '0;
            clrBusy_q <= 1'b0;
          end else begin
            clrCnt_q <= clrCnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= RF_IDLE;
          clrCnt_q  <= '0;
          clrBusy_q <= 1'b0;
        end
      endcase
    end
  end

  // Read ports. Port 1 bypass is applied before port 0 so that port 0 wins
  // a collision, mirroring the storage priority. A matching long-latency
  // write means the awaited value is on the bus now, so busy is dropped.
  always_comb begin
    logic [AW-1:0] rdA;
    rdData = '0;
    rdBusy = '0;
    for (int k = 0; k < NRD; k++) begin
      rdA = rfBus.rd_addr[k*AW +: AW];
      if (!isR0(rdA)) begin
        rdData[k*DW +: DW] = regFile_q[rdA];
        rdBusy[k]          = sbBusy[k];
        if (bypOn && wr1En && rfBus.waddr1 == rdA) begin
          rdData[k*DW +: DW] = rfBus.wdata1;
          rdBusy[k]          = 1'b0;
        end
        if (bypOn && wr0En && rfBus.waddr0 == rdA) begin
          rdData[k*DW +: DW] = rfBus.wdata0;
        end
      end
    end
  end

  assign rfBus.rd_data  = rdData;
  assign rfBus.rd_busy  = rdBusy;
  assign rfBus.hi_rdata = (bypOn && hiloEn) ? rfBus.hi_wdata : hi_q;
  assign rfBus.lo_rdata = (bypOn && hiloEn) ? rfBus.lo_wdata : lo_q;
  assign rfBus.clr_busy = clrBusy_q;

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed bench for rf_multiport_sb: bypass, write collisions, scoreboard,
// HI/LO, the soft-clear sweep and asynchronous reset in the middle of it.
module tb_rf_multiport_sb;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cycle;

  rf_multiport_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) rfBus ();

  rf_multiport_sb #(
    .DW      (DW),
    .AW      (AW),
    .NRD     (NRD),
    .ZERO_R0 (1),
    .BYPASS  (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rfBus (rfBus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives both write ports in one call; everything else is set directly.
  task automatic applyStimulus(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    rfBus.we0    = w0;
    rfBus.waddr0 = a0;
    rfBus.wdata0 = d0;
    rfBus.we1    = w1;
    rfBus.waddr1 = a1;
    rfBus.wdata1 = d1;
  endtask

  task automatic setRead(input int k, input logic [AW-1:0] a);
    rfBus.rd_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rdData(input int k);
    return rfBus.rd_data[k*DW +: DW];
  endfunction

  function automatic logic [31:0] rdBusy(input int k);
    return {31'd0, rfBus.rd_busy[k]};
  endfunction

  initial begin
    rst             = 1'b1;
    rfBus.rd_addr   = '0;
    rfBus.res_valid = 1'b0;
    rfBus.res_addr  = '0;
    rfBus.hilo_we   = 1'b0;
    rfBus.hi_wdata  = '0;
    rfBus.lo_wdata  = '0;
    rfBus.clr_req   = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_rd0", rdData(0), 32'h0);
    checkOutput("reset_rd1", rdData(1), 32'h0);
    checkOutput("reset_busy0", rdBusy(0), 32'h0);
    checkOutput("reset_hi", rfBus.hi_rdata, 32'h0);
    checkOutput("reset_clr_busy", {31'd0, rfBus.clr_busy}, 32'h0);

    // Port 0 write to r5 is visible in the same cycle, then stored.
    @(negedge clk);
    setRead(0, 5);
    applyStimulus(1, 5, 32'h1234_5678, 0, 0, 0);
    #1 checkOutput("byp_w0_r5", rdData(0), 32'h1234_5678);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("stored_r5", rdData(0), 32'h1234_5678);

    // r0 is hardwired: no bypass and nothing stored.
    applyStimulus(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    setRead(0, 0);
    #1 checkOutput("r0_no_bypass", rdData(0), 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("r0_not_stored", rdData(0), 32'h0);

    // Reserve r7, then collide both write ports on it.
    rfBus.res_valid = 1'b1;
    rfBus.res_addr  = 7;
    @(negedge clk);
    rfBus.res_valid = 1'b0;
    setRead(1, 7);
    #1 checkOutput("r7_reserved", rdBusy(1), 32'h1);
    applyStimulus(1, 7, 32'h0000_AAAA, 1, 7, 32'h0000_BBBB);
    #1 checkOutput("r7_byp_port0_wins", rdData(1), 32'h0000_AAAA);
    checkOutput("r7_byp_busy_forced", rdBusy(1), 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("r7_stored_port0", rdData(1), 32'h0000_AAAA);
    checkOutput("r7_busy_released", rdBusy(1), 32'h0);

    // Scoreboard on r9: reserve, release, then reserve+release together.
    setRead(0, 9);
    rfBus.res_valid = 1'b1;
    rfBus.res_addr  = 9;
    #1 checkOutput("r9_busy_not_yet", rdBusy(0), 32'h0);
    @(negedge clk);
    rfBus.res_valid = 1'b0;
    #1 checkOutput("r9_busy_set", rdBusy(0), 32'h1);
    applyStimulus(0, 0, 0, 1, 9, 32'h42);
    #1 checkOutput("r9_w1_byp_busy", rdBusy(0), 32'h0);
    checkOutput("r9_w1_byp_data", rdData(0), 32'h42);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("r9_busy_cleared", rdBusy(0), 32'h0);
    checkOutput("r9_stored", rdData(0), 32'h42);
    rfBus.res_valid = 1'b1;
    rfBus.res_addr  = 9;
    applyStimulus(0, 0, 0, 1, 9, 32'h55);
    #1 checkOutput("r9_both_byp_data", rdData(0), 32'h55);
    @(negedge clk);
    rfBus.res_valid = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("r9_reserve_wins", rdBusy(0), 32'h1);
    checkOutput("r9_both_stored", rdData(0), 32'h55);

    // HI/LO write-through and hold.
    rfBus.hilo_we  = 1'b1;
    rfBus.hi_wdata = 32'hDEAD;
    rfBus.lo_wdata = 32'hBEEF;
    #1 checkOutput("hi_bypass", rfBus.hi_rdata, 32'hDEAD);
    checkOutput("lo_bypass", rfBus.lo_rdata, 32'hBEEF);
    @(negedge clk);
    rfBus.hilo_we  = 1'b0;
    rfBus.hi_wdata = '0;
    rfBus.lo_wdata = '0;
    #1 checkOutput("hi_held", rfBus.hi_rdata, 32'hDEAD);
    checkOutput("lo_held", rfBus.lo_rdata, 32'hBEEF);

    // Fill r1..r31 with their index; port 0 writes must not touch busy.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      applyStimulus(1, 5'(i), 32'(i), 0, 0, 0);
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("fill_r9", rdData(0), 32'd9);
    checkOutput("fill_r9_busy_kept", rdBusy(0), 32'h1);

    // Soft clear: r3 is swept at the end of cycle 4, r20 at the end of
    // cycle 21. Writes/reserves in cycle 2 and a second request in cycle 5
    // must all be ignored.
    setRead(0, 3);
    setRead(1, 20);
    rfBus.clr_req = 1'b1;
    #1 checkOutput("clr_busy_before_edge", {31'd0, rfBus.clr_busy}, 32'h0);
    @(negedge clk);
    rfBus.clr_req = 1'b0;
    cycle = 0;
    while (rfBus.clr_busy === 1'b1 && cycle < 100) begin
      cycle++;
      if (cycle == 2) begin
        applyStimulus(1, 3, 32'hFFFF, 0, 0, 0);
        rfBus.hilo_we   = 1'b1;
        rfBus.hi_wdata  = 32'h1111;
        rfBus.res_valid = 1'b1;
        rfBus.res_addr  = 5;
      end else begin
        applyStimulus(0, 0, 0, 0, 0, 0);
        rfBus.hilo_we   = 1'b0;
        rfBus.hi_wdata  = '0;
        rfBus.res_valid = 1'b0;
      end
      rfBus.clr_req = (cycle == 5);
      #1;
      checkOutput($sformatf("clr_c%0d_r3", cycle), rdData(0), (cycle <= 4) ? 32'd3 : 32'd0);
      checkOutput($sformatf("clr_c%0d_r20", cycle), rdData(1), (cycle <= 21) ? 32'd20 : 32'd0);
      if (cycle == 2) begin
        checkOutput("clr_hi_zeroed_no_byp", rfBus.hi_rdata, 32'h0);
      end
      @(negedge clk);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    rfBus.hilo_we   = 1'b0;
    rfBus.res_valid = 1'b0;
    rfBus.clr_req   = 1'b0;
    checkOutput("clr_length", 32'(cycle), 32'd32);
    for (int i = 0; i < 32; i++) begin
      setRead(0, 5'(i));
      #1;
      checkOutput($sformatf("post_clr_r%0d", i), rdData(0), 32'h0);
      checkOutput($sformatf("post_clr_busy%0d", i), rdBusy(0), 32'h0);
    end
    checkOutput("post_clr_hi", rfBus.hi_rdata, 32'h0);
    checkOutput("post_clr_lo", rfBus.lo_rdata, 32'h0);

    // Asynchronous reset at clear cycle 10.
    @(negedge clk);
    applyStimulus(1, 20, 32'h77, 0, 0, 0);
    rfBus.res_valid = 1'b1;
    rfBus.res_addr  = 12;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rfBus.res_valid = 1'b0;
    setRead(0, 20);
    setRead(1, 12);
    #1 checkOutput("pre_rst_r20", rdData(0), 32'h77);
    checkOutput("pre_rst_busy12", rdBusy(1), 32'h1);
    rfBus.clr_req = 1'b1;
    @(negedge clk);
    rfBus.clr_req = 1'b0;
    repeat (9) @(negedge clk);
    #1 checkOutput("c10_clr_busy", {31'd0, rfBus.clr_busy}, 32'h1);
    checkOutput("c10_busy12_pending", rdBusy(1), 32'h1);
    checkOutput("c10_r20_pending", rdData(0), 32'h77);
    #1 rst = 1'b1;
    #1 checkOutput("rst_clr_busy", {31'd0, rfBus.clr_busy}, 32'h0);
    checkOutput("rst_r20", rdData(0), 32'h0);
    checkOutput("rst_busy12", rdBusy(1), 32'h0);
    checkOutput("rst_hi", rfBus.hi_rdata, 32'h0);
    checkOutput("rst_lo", rfBus.lo_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 4, 32'h99, 0, 0, 0);
    setRead(0, 4);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1 checkOutput("after_rst_idle", {31'd0, rfBus.clr_busy}, 32'h0);
    checkOutput("after_rst_r4", rdData(0), 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
